// File: rtl/weight_fetch_ctrl_if.sv
// Handshake and memory bus between the control unit, the weight memory,
// the systolic-array weight-load path and weight_fetch_ctrl.
interface weight_fetch_ctrl_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  num_tiles;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_w1;
    logic [DATA_W-1:0] mem_w2;
    logic [DATA_W-1:0] mem_w3;
    logic [DATA_W-1:0] mem_w4;
    logic [DATA_W-1:0] w_out1;
    logic [DATA_W-1:0] w_out2;
    logic [DATA_W-1:0] w_out3;
    logic [DATA_W-1:0] w_out4;
    logic              w_valid;
    logic              w_ready;
    logic [CNT_W-1:0]  tiles_left;

    // Controller/memory/array side.
    modport master (
        output start, base_addr, num_tiles, mem_w1, mem_w2, mem_w3, mem_w4, w_ready,
        input  busy, done, mem_addr, w_out1, w_out2, w_out3, w_out4, w_valid, tiles_left
    );

    // Fetch controller side.
    modport slave (
        input  start, base_addr, num_tiles, mem_w1, mem_w2, mem_w3, mem_w4, w_ready,
        output busy, done, mem_addr, w_out1, w_out2, w_out3, w_out4, w_valid, tiles_left
    );
endinterface

// File: rtl/weight_fetch_ctrl.sv
// Walks weight memory tile by tile, registers each 4-weight tile and holds it
// on a valid/ready handshake to the systolic array; pulses done at the end.
module weight_fetch_ctrl #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 16,
    parameter int TILE_STRIDE = 4,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    weight_fetch_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_e;

    state_e                       state_q,      state_d;
    logic [ADDR_W-1:0]            mem_addr_q,   mem_addr_d;
    logic [CNT_W-1:0]             tiles_left_q, tiles_left_d;
    logic [3:0][DATA_W-1:0]       w_q,          w_d;
    logic                         w_valid_q,    w_valid_d;
    logic                         done_q,       done_d;
    logic [3:0][DATA_W-1:0]       mem_w;

    assign mem_w = {bus.mem_w4, bus.mem_w3, bus.mem_w2, bus.mem_w1};

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        tiles_left_d = tiles_left_q;
        w_d          = w_q;
        w_valid_d    = w_valid_q;
        done_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.num_tiles != '0) begin
                        mem_addr_d   = bus.base_addr;
                        tiles_left_d = bus.num_tiles;
                        state_d      = FETCH;
                    end else begin
                        // Empty command: complete immediately, address and tile untouched.
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            FETCH: begin
                w_d       = mem_w;
                w_valid_d = 1'b1;
                state_d   = PRESENT;
            end
            PRESENT: begin
                if (bus.w_ready) begin
                    w_valid_d = 1'b0;
                    if (tiles_left_q == CNT_W'(1)) begin
                        tiles_left_d = '0;
                        state_d      = DONE;
                        done_d       = 1'b1;
                    end else begin
                        tiles_left_d = tiles_left_q - CNT_W'(1);
                        // Wraps modulo 2^ADDR_W by width truncation.
                        mem_addr_d   = mem_addr_q + ADDR_W'(TILE_STRIDE);
                        state_d      = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            tiles_left_q <= '0;
            w_q          <= '0;
            w_valid_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            tiles_left_q <= tiles_left_d;
            w_q          <= w_d;
            w_valid_q    <= w_valid_d;
            done_q       <= done_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.tiles_left = tiles_left_q;
    assign bus.w_valid    = w_valid_q;
    assign bus.w_out1     = w_q[0];
    assign bus.w_out2     = w_q[1];
    assign bus.w_out3     = w_q[2];
    assign bus.w_out4     = w_q[3];
endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: cycle table, directed corner sequences and a
// randomized run checked against a transaction-level model of the fetch walk.
module tb_weight_fetch_ctrl;
    localparam int AW = 13;
    localparam int DW = 16;
    localparam int CW = 8;
    localparam int TS = 4;
    localparam logic [63:0] T1 = 64'h0003_0005_0004_0006;
    localparam logic [63:0] T2 = 64'h0007_0008_0009_000a;
    localparam logic [63:0] T3 = 64'h000b_000c_000d_000e;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    weight_fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus();
    weight_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TILE_STRIDE(TS), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_comb begin
        bus.mem_w1 = mem[bus.mem_addr];
        bus.mem_w2 = mem[AW'(bus.mem_addr + AW'(1))];
        bus.mem_w3 = mem[AW'(bus.mem_addr + AW'(2))];
        bus.mem_w4 = mem[AW'(bus.mem_addr + AW'(3))];
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] pk(input logic b, input logic d, input logic v,
                                        input logic [AW-1:0] a, input logic [CW-1:0] tl,
                                        input logic cw, input logic [63:0] w);
        return {40'h0, b, d, v, a, tl, (cw ? w : 64'h0)};
    endfunction

    function automatic logic [127:0] snap(input logic cw);
        return pk(bus.busy, bus.done, bus.w_valid, bus.mem_addr, bus.tiles_left, cw,
                  {bus.w_out1, bus.w_out2, bus.w_out3, bus.w_out4});
    endfunction

    function automatic logic [63:0] tile_at(input logic [AW-1:0] a);
        return {mem[a], mem[AW'(a + AW'(1))], mem[AW'(a + AW'(2))], mem[AW'(a + AW'(3))]};
    endfunction

    typedef struct {
        logic          start;
        logic [AW-1:0] base;
        logic [CW-1:0] num;
        logic          rdy;
        logic          busy;
        logic          done;
        logic          valid;
        logic [AW-1:0] addr;
        logic [CW-1:0] tl;
        logic          cw;
        logic [63:0]   w;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic [AW-1:0] b, input logic [CW-1:0] n,
                                input logic r, input logic eb, input logic ed, input logic ev,
                                input logic [AW-1:0] ea, input logic [CW-1:0] et,
                                input logic cw, input logic [63:0] w);
        vec_t v;
        v.start = s; v.base = b; v.num = n; v.rdy = r;
        v.busy = eb; v.done = ed; v.valid = ev; v.addr = ea; v.tl = et; v.cw = cw; v.w = w;
        return v;
    endfunction

    vec_t vec [0:20];

    initial begin
        bus.start = 1'b0; bus.base_addr = '0; bus.num_tiles = '0; bus.w_ready = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        {mem[0], mem[1], mem[2], mem[3]} = T1;
        {mem[4], mem[5], mem[6], mem[7]} = T2;
        {mem[13'h1ffc], mem[13'h1ffd], mem[13'h1ffe], mem[13'h1fff]} = T3;

        // Row: inputs applied this cycle | outputs expected before the next edge.
        vec[0]  = mk(1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0);
        vec[1]  = mk(0, 0, 0, 1,  1, 0, 0, 0, 1, 0, 0);
        vec[2]  = mk(0, 0, 0, 1,  1, 0, 1, 0, 1, 1, T1);
        vec[3]  = mk(0, 0, 0, 1,  1, 1, 0, 0, 0, 0, 0);
        vec[4]  = mk(0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
        vec[5]  = mk(1, 0, 2, 0,  0, 0, 0, 0, 0, 0, 0);
        vec[6]  = mk(0, 0, 0, 0,  1, 0, 0, 0, 2, 0, 0);
        for (int i = 7; i <= 11; i++) vec[i] = mk(0, 0, 0, 0,  1, 0, 1, 0, 2, 1, T1);
        vec[12] = mk(0, 0, 0, 1,  1, 0, 1, 0, 2, 1, T1);
        vec[13] = mk(0, 0, 0, 1,  1, 0, 0, 4, 1, 0, 0);
        vec[14] = mk(0, 0, 0, 1,  1, 0, 1, 4, 1, 1, T2);
        vec[15] = mk(0, 0, 0, 1,  1, 1, 0, 4, 0, 0, 0);
        vec[16] = mk(0, 0, 0, 0,  0, 0, 0, 4, 0, 0, 0);
        vec[17] = mk(1, 13'h100, 0, 0,  0, 0, 0, 4, 0, 0, 0);
        vec[18] = mk(1, 0, 1, 0,  1, 1, 0, 4, 0, 0, 0);
        vec[19] = mk(0, 0, 0, 0,  0, 0, 0, 4, 0, 0, 0);
        vec[20] = mk(0, 0, 0, 0,  0, 0, 0, 4, 0, 0, 0);

        repeat (2) @(negedge clk);
        chk("reset_values", snap(1'b1), 128'h0);
        reset = 1'b0;

        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            bus.start = vec[i].start; bus.base_addr = vec[i].base;
            bus.num_tiles = vec[i].num; bus.w_ready = vec[i].rdy;
            chk($sformatf("row%0d", i), snap(vec[i].cw),
                pk(vec[i].busy, vec[i].done, vec[i].valid, vec[i].addr, vec[i].tl, vec[i].cw, vec[i].w));
        end

        // Asynchronous reset between edges, with mem_addr and w_out nonzero.
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("async_reset", snap(1'b1), 128'h0);
        @(negedge clk);
        reset = 1'b0;

        // Address wrap with a start pulse during FETCH and PRESENT that must be ignored.
        @(negedge clk);
        chk("wrap_idle", snap(1'b0), pk(0, 0, 0, 0, 0, 0, 0));
        bus.start = 1; bus.base_addr = 13'h1ffc; bus.num_tiles = 2; bus.w_ready = 1;
        @(negedge clk);
        chk("wrap_fetch", snap(1'b0), pk(1, 0, 0, 13'h1ffc, 2, 0, 0));
        bus.start = 1; bus.base_addr = 13'h0040; bus.num_tiles = 5;
        @(negedge clk);
        chk("wrap_present", snap(1'b1), pk(1, 0, 1, 13'h1ffc, 2, 1, T3));
        bus.w_ready = 0;
        @(negedge clk);
        chk("wrap_hold", snap(1'b1), pk(1, 0, 1, 13'h1ffc, 2, 1, T3));
        bus.start = 0; bus.w_ready = 1;
        @(negedge clk);
        chk("wrap_addr", snap(1'b0), pk(1, 0, 0, 13'h0000, 1, 0, 0));
        @(negedge clk);
        chk("wrap_tile2", snap(1'b1), pk(1, 0, 1, 13'h0000, 1, 1, T1));
        @(negedge clk);
        chk("wrap_done", snap(1'b0), pk(1, 1, 0, 13'h0000, 0, 0, 0));
        @(negedge clk);
        chk("wrap_after", snap(1'b0), pk(0, 0, 0, 13'h0000, 0, 0, 0));

        // Reset while presenting the first of three tiles.
        begin
            int dones, hs;
            bit seen;
            logic [63:0] got;
            bus.start = 1; bus.base_addr = 0; bus.num_tiles = 3; bus.w_ready = 0;
            @(negedge clk);
            bus.start = 0;
            @(negedge clk);
            chk("mid_present", snap(1'b1), pk(1, 0, 1, 0, 3, 1, T1));
            reset = 1'b1;
            #1 chk("mid_reset", snap(1'b1), 128'h0);
            dones = 0;
            repeat (3) begin
                @(negedge clk);
                dones += int'(bus.done);
            end
            chk("mid_no_done", 128'(dones), 128'h0);
            reset = 1'b0;
            bus.start = 1; bus.base_addr = 0; bus.num_tiles = 1; bus.w_ready = 1;
            hs = 0; seen = 0; got = '0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                bus.start = 0;
                if (bus.done) seen = 1;
                else if (bus.w_valid && bus.w_ready) begin
                    hs++;
                    got = {bus.w_out1, bus.w_out2, bus.w_out3, bus.w_out4};
                end
            end
            chk("mid_restart", {31'h0, seen, 32'(hs), got}, {31'h0, 1'b1, 32'd1, T1});
        end

        // Randomized commands against a transaction-level model of the walk.
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        for (int t = 0; t < 40; t++) begin
            int n, hs, cyc, last, firstv;
            bit seen;
            logic [AW-1:0] b;
            logic [63:0] eq[$];
            logic [AW-1:0] ea[$];
            n = (t % 7 == 0) ? 0 : int'($urandom_range(1, 5));
            b = (t % 5 == 1) ? AW'(13'h1ff8) : AW'($urandom);
            eq.delete(); ea.delete();
            for (int i = 0; i < n; i++) begin
                logic [AW-1:0] a;
                a = AW'(int'(b) + TS * i);
                ea.push_back(a);
                eq.push_back(tile_at(a));
            end
            @(negedge clk);
            chk("rnd_idle", 128'(bus.busy), 128'h0);
            bus.start = 1; bus.base_addr = b; bus.num_tiles = CW'(n);
            bus.w_ready = 1'($urandom);
            hs = 0; cyc = 0; last = 0; firstv = -1; seen = 0;
            while (!seen && cyc < 400) begin
                @(negedge clk);
                cyc++;
                if (bus.done) begin
                    seen = 1;
                    bus.start = 0;
                    chk($sformatf("rnd_done t%0d", t), {32'h0, 32'(hs), 32'(cyc), 32'(firstv)},
                        {32'h0, 32'(n), 32'(last + 1), (n == 0) ? 32'hffff_ffff : 32'd2});
                end else begin
                    bus.start = 1'($urandom);
                    bus.base_addr = AW'($urandom);
                    bus.num_tiles = CW'($urandom);
                    bus.w_ready = 1'($urandom);
                    if (bus.w_valid && firstv < 0) firstv = cyc;
                    if (bus.w_valid && bus.w_ready) begin
                        if (hs < n)
                            chk($sformatf("rnd_hs t%0d #%0d", t, hs),
                                {43'h0, bus.w_out1, bus.w_out2, bus.w_out3, bus.w_out4, bus.mem_addr, bus.tiles_left},
                                {43'h0, eq[hs], ea[hs], CW'(n - hs)});
                        else
                            chk($sformatf("rnd_extra_hs t%0d", t), 128'(hs), 128'(n - 1));
                        hs++;
                        last = cyc;
                    end
                end
            end
            if (!seen) chk($sformatf("rnd_timeout t%0d", t), 128'h0, 128'h1);
        end
        bus.start = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
